// File: rtl/fft_frame_ctrl_pkg.sv
// fft_frame_ctrl_pkg: shared sizes, state enum and bank-major position type for the frame sequencer
package fft_frame_ctrl_pkg;
  localparam int N_BANK = 4;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 2;
  localparam int START_GAP = 2;
  localparam int FRAME_LEN = N_BANK << ADDR_W;
  localparam int POS_W = $clog2(FRAME_LEN);
  typedef enum logic [2:0] {IDLE, FILL, LAUNCH, WAIT_FFT, DRAIN} state_t;
  typedef struct packed {
    logic [$clog2(N_BANK)-1:0] bank;
    logic [ADDR_W-1:0] addr;
  } pos_t;
  function automatic pos_t next_pos(pos_t p);
    return pos_t'(p + 1'b1);
  endfunction
endpackage

// File: rtl/fft_frame_ctrl_if.sv
// fft_frame_ctrl_if: ADC stream, fft_top RAM/control and result stream of the frame sequencer
interface fft_frame_ctrl_if;
  import fft_frame_ctrl_pkg::*;
  logic enable;
  logic [DATA_W-1:0] adc_data;
  logic adc_valid, adc_ready;
  logic [DATA_W-1:0] fft_data;
  logic [N_BANK*ADDR_W-1:0] fft_addr_wr, fft_addr_rd;
  logic [N_BANK-1:0] fft_we;
  logic fft_start, fft_rdy;
  logic [N_BANK*DATA_W-1:0] fft_re;
  logic [DATA_W-1:0] out_data;
  logic out_valid, out_ready;
  logic busy, frame_done, err;
  modport master (
    input enable, adc_data, adc_valid, fft_rdy, fft_re, out_ready,
    output adc_ready, fft_data, fft_addr_wr, fft_we, fft_start, fft_addr_rd,
    output out_data, out_valid, busy, frame_done, err
  );
  modport slave (
    output enable, adc_data, adc_valid, fft_rdy, fft_re, out_ready,
    input adc_ready, fft_data, fft_addr_wr, fft_we, fft_start, fft_addr_rd,
    input out_data, out_valid, busy, frame_done, err
  );
endinterface

// File: rtl/fft_frame_ctrl_skid.sv
// fft_frame_ctrl_skid: small FIFO absorbing reads already in flight when the result sink stalls
module fft_frame_ctrl_skid
  import fft_frame_ctrl_pkg::*;
#(
  parameter int DEPTH = RD_LAT + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign in_ready = cnt != CW'(DEPTH);
  assign out_valid = cnt != '0;
  assign out_data = mem[rp];
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wp] <= in_data;
      if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: fills fft_top input banks from the ADC stream, launches the FFT, drains the results
// Define FFT_CTRL_TIMEOUT_EN to abort WAIT_FFT after TMO_CYC cycles and raise err.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
`ifdef FFT_CTRL_TIMEOUT_EN
#(
  parameter int TMO_CYC = 65536
)
`endif
(
  input logic clk,
  input logic rst_n,
  fft_frame_ctrl_if.master bus
);
  localparam int DEPTH = RD_LAT + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(START_GAP + 2);
  localparam int RW = POS_W + 1;
  state_t state, state_nx;
  pos_t wpos, rpos;
  logic [RW-1:0] rcnt;
  logic [POS_W-1:0] ocnt;
  logic [CW-1:0] cred;
  logic [GW-1:0] gap;
  logic [RD_LAT:0] pv;
  logic [$clog2(N_BANK)-1:0] pb [RD_LAT+1];
  logic accept, issue, pop, done, rdy_ok, tmo_hit, sk_ready;
  assign bus.busy = state != IDLE;
  assign bus.adc_ready = state == FILL && (bus.enable || wpos != '0);
  assign accept = bus.adc_valid && bus.adc_ready;
  assign rdy_ok = gap > GW'(START_GAP) && bus.fft_rdy;
  assign rpos = pos_t'(rcnt[POS_W-1:0]);
  // a read is only issued when its result is guaranteed a skid slot
  assign issue = state == DRAIN && !rcnt[POS_W] && cred < CW'(DEPTH);
  assign pop = bus.out_valid && bus.out_ready;
  assign done = pop && ocnt == '1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = bus.enable ? FILL : IDLE;
      FILL:     state_nx = !bus.adc_ready ? IDLE : (accept && wpos == '1) ? LAUNCH : FILL;
      LAUNCH:   state_nx = WAIT_FFT;
      WAIT_FFT: state_nx = rdy_ok ? DRAIN : tmo_hit ? IDLE : WAIT_FFT;
      DRAIN:    state_nx = done ? IDLE : DRAIN;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wpos <= '0;
      rcnt <= '0;
      ocnt <= '0;
      cred <= '0;
      gap <= '0;
      pv <= '0;
      for (int i = 0; i <= RD_LAT; i++) pb[i] <= '0;
      bus.fft_data <= '0;
      bus.fft_addr_wr <= '0;
      bus.fft_we <= '0;
      bus.fft_start <= 1'b0;
      bus.fft_addr_rd <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) wpos <= '0;
      else if (accept) wpos <= next_pos(wpos);
      rcnt <= state == DRAIN ? rcnt + RW'(issue) : '0;
      ocnt <= state == DRAIN ? ocnt + POS_W'(pop) : '0;
      cred <= state == DRAIN ? cred + CW'(issue) - CW'(pop) : '0;
      gap <= state != WAIT_FFT ? '0 : gap + GW'(gap <= GW'(START_GAP));
      pv <= {pv[RD_LAT-1:0], issue};
      pb[0] <= rpos.bank;
      for (int i = 1; i <= RD_LAT; i++) pb[i] <= pb[i-1];
      bus.fft_we <= accept ? N_BANK'(1) << wpos.bank : '0;
      if (accept) bus.fft_data <= bus.adc_data;
      if (accept) bus.fft_addr_wr[wpos.bank*ADDR_W +: ADDR_W] <= wpos.addr;
      bus.fft_start <= state == LAUNCH;
      if (issue) bus.fft_addr_rd <= {N_BANK{rpos.addr}};
      bus.frame_done <= done;
    end
  end
`ifdef FFT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC);
  logic [TW-1:0] tmo;
  assign tmo_hit = state == WAIT_FFT && !rdy_ok && tmo == TW'(TMO_CYC - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo <= '0;
      bus.err <= 1'b0;
    end else begin
      tmo <= state == WAIT_FFT ? tmo + 1'b1 : '0;
      bus.err <= bus.enable && (bus.err || tmo_hit);
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign bus.err = 1'b0;
`endif
  fft_frame_ctrl_skid #(.DEPTH(DEPTH)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(bus.fft_re[pb[RD_LAT]*DATA_W +: DATA_W]),
    .in_valid(pv[RD_LAT] && sk_ready),
    .in_ready(sk_ready),
    .out_data(bus.out_data),
    .out_valid(bus.out_valid),
    .out_ready(bus.out_ready)
  );
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench with an fft_top stub (RDY after a delay, read data = {bank,addr})
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
  import fft_frame_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int since = 0;
  int rdy_delay = 50;
  logic armed = 1'b0;
  logic rdy_hold = 1'b0;
  logic [DATA_W-1:0] re1 [N_BANK];
  logic [DATA_W-1:0] re2 [N_BANK];
  fft_frame_ctrl_if bus();
`ifdef FFT_CTRL_TIMEOUT_EN
  fft_frame_ctrl #(.TMO_CYC(100)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
`else
  fft_frame_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.fft_start) begin
      since <= 1;
      armed <= 1'b1;
    end else if (since < 1000000) since <= since + 1;
    for (int b = 0; b < N_BANK; b++) begin
      re1[b] <= {5'b0, 2'(b), bus.fft_addr_rd[b*ADDR_W +: ADDR_W]};
      re2[b] <= re1[b];
    end
  end
  assign bus.fft_rdy = rdy_hold || (armed && since >= rdy_delay);
  for (genvar g = 0; g < N_BANK; g++) begin : g_re
    assign bus.fft_re[g*DATA_W +: DATA_W] = re2[g];
  end

  task automatic test_reset();
    rst_n = 0;
    bus.enable = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.adc_ready, bus.fft_we, bus.fft_start, bus.out_valid, bus.frame_done, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0", {bus.busy, bus.adc_ready, bus.fft_we, bus.fft_start, bus.out_valid, bus.frame_done, bus.err});
    end
    checks++;
    if ({bus.fft_addr_wr, bus.fft_addr_rd} !== '0) begin
      errors++;
      $display("FAIL reset_addr got=%h want=0", {bus.fft_addr_wr, bus.fft_addr_rd});
    end
    checks++;
    if ({bus.fft_data, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {bus.fft_data, bus.out_data});
    end
    bus.enable = 0;
    rst_n = 1;
  endtask

  task automatic test_enable();
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_hold busy=%b want=0", bus.busy); end
    bus.enable = 1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.adc_ready} !== 2'b11) begin
      errors++;
      $display("FAIL enter_fill busy,ready=%b want=11", {bus.busy, bus.adc_ready});
    end
    bus.enable = 0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.fft_we} !== '0) begin
      errors++;
      $display("FAIL abort_fill busy,we=%b want=0", {bus.busy, bus.fft_we});
    end
  endtask

  task automatic test_fill(input bit toggle, output int s_cyc);
    int sent, seen, bad, starts, last_we;
    logic [N_BANK-1:0] lw_we;
    logic [ADDR_W-1:0] lw_addr;
    int bank, addr;
    sent = 0; seen = 0; bad = 0; starts = 0; last_we = -100; s_cyc = -1000;
    lw_we = '0; lw_addr = '0;
    bus.enable = 1;
    bus.out_ready = 0;
    for (int t = 0; t < 9000 && !(starts > 0 && cyc > s_cyc + 3); t++) begin
      @(negedge clk);
      if (bus.fft_we != '0) begin
        bank = seen >> ADDR_W;
        addr = seen % (1 << ADDR_W);
        if (seen >= FRAME_LEN || bus.fft_we !== N_BANK'(1 << bank) ||
            bus.fft_addr_wr[bank*ADDR_W +: ADDR_W] !== ADDR_W'(addr) ||
            bus.fft_data !== (toggle ? DATA_W'(seen) : DATA_W'(100))) bad++;
        lw_we = bus.fft_we;
        lw_addr = bus.fft_addr_wr[3*ADDR_W +: ADDR_W];
        last_we = cyc;
        seen++;
      end
      if (bus.fft_start) begin starts++; s_cyc = cyc; end
      bus.adc_valid = sent < FRAME_LEN && (!toggle || cyc % 2 == 0);
      bus.adc_data = toggle ? DATA_W'(sent) : DATA_W'(100);
      if (sent >= 1) bus.enable = 0;
      if (bus.adc_valid && bus.adc_ready) sent++;
    end
    bus.adc_valid = 0;
    checks++;
    if (seen != FRAME_LEN) begin errors++; $display("FAIL fill_count got=%0d want=%0d", seen, FRAME_LEN); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_order bad_writes=%0d want=0", bad); end
    checks++;
    if (lw_we !== 4'b1000 || lw_addr !== 9'd511) begin
      errors++;
      $display("FAIL fill_last we=%b addr=%0d want 1000/511", lw_we, lw_addr);
    end
    checks++;
    if (starts != 1) begin errors++; $display("FAIL start_count got=%0d want=1", starts); end
    checks++;
    if (s_cyc - last_we != 1) begin errors++; $display("FAIL start_delay got=%0d want=1", s_cyc - last_we); end
  endtask

  task automatic test_drain(input bit rnd, input int s_cyc, input int lat);
    int got, bad, dones, first, extra;
    logic done_busy;
    got = 0; bad = 0; dones = 0; first = -1; extra = 0; done_busy = 1'b0;
    for (int t = 0; t < 20000 && dones == 0; t++) begin
      @(negedge clk);
      if (bus.frame_done) begin dones++; done_busy = bus.busy; end
      if (bus.out_valid && first < 0) first = cyc;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_data !== DATA_W'(got)) bad++;
        got++;
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.frame_done) dones++;
      if (bus.out_valid) extra++;
    end
    checks++;
    if (first - s_cyc != lat) begin errors++; $display("FAIL drain_latency got=%0d want=%0d", first - s_cyc, lat); end
    checks++;
    if (got != FRAME_LEN) begin errors++; $display("FAIL drain_count got=%0d want=%0d", got, FRAME_LEN); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL drain_data bad_beats=%0d want=0", bad); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL frame_done_count got=%0d want=1", dones); end
    checks++;
    if (done_busy !== 1'b0 || extra != 0) begin
      errors++;
      $display("FAIL drain_end busy_at_done=%b extra_valid=%0d want 0/0", done_busy, extra);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    test_fill(1'b0, s);
    test_drain(1'b1, s, 55);
    test_fill(1'b1, s);
    test_drain(1'b0, s, 55);
  endtask

  task automatic test_start_gap();
    int s;
    rdy_hold = 1;
    test_fill(1'b0, s);
    test_drain(1'b0, s, 8);
    rdy_hold = 0;
  endtask

  task automatic test_reset_mid();
    int sent, got, bad, s;
    sent = 0;
    bus.enable = 1;
    bus.adc_valid = 1;
    bus.adc_data = 16'h55;
    for (int t = 0; t < 5000 && sent < 1000; t++) begin
      @(negedge clk);
      if (bus.adc_valid && bus.adc_ready) sent++;
    end
    rst_n = 0;
    bus.adc_valid = 0;
    @(negedge clk);
    checks++;
    if (sent != 1000) begin errors++; $display("FAIL mid_fill_beats got=%0d want=1000", sent); end
    checks++;
    if ({bus.busy, bus.adc_ready, bus.fft_we, bus.fft_start, bus.fft_addr_wr, bus.fft_data} !== '0) begin
      errors++;
      $display("FAIL mid_fill_reset got=%h want=0", {bus.busy, bus.adc_ready, bus.fft_we, bus.fft_start, bus.fft_addr_wr, bus.fft_data});
    end
    rst_n = 1;
    test_fill(1'b0, s);
    got = 0; bad = 0;
    for (int t = 0; t < 5000 && got < 500; t++) begin
      @(negedge clk);
      bus.out_ready = 1;
      if (bus.out_valid) begin
        if (bus.out_data !== DATA_W'(got)) bad++;
        got++;
      end
    end
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (got != 500 || bad != 0) begin errors++; $display("FAIL mid_drain_beats got=%0d bad=%0d want 500/0", got, bad); end
    checks++;
    if ({bus.busy, bus.out_valid, bus.frame_done, bus.fft_addr_rd} !== '0) begin
      errors++;
      $display("FAIL mid_drain_reset got=%h want=0", {bus.busy, bus.out_valid, bus.frame_done, bus.fft_addr_rd});
    end
    rst_n = 1;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle busy,valid=%b want=00", {bus.busy, bus.out_valid});
    end
  endtask

  task automatic test_timeout();
    int s, ov;
    ov = 0;
    rdy_delay = 1 << 30;
    test_fill(1'b0, s);
`ifdef FFT_CTRL_TIMEOUT_EN
    bus.enable = 1;
    while (cyc < s + 99) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    checks++;
    if ({bus.err, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL tmo_before err,busy=%b want=01", {bus.err, bus.busy});
    end
    @(negedge clk);
    checks++;
    if ({bus.err, bus.busy, bus.frame_done} !== 3'b100 || ov != 0) begin
      errors++;
      $display("FAIL tmo_hit err,busy,done=%b outs=%0d want 100/0", {bus.err, bus.busy, bus.frame_done}, ov);
    end
    bus.enable = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.err, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL tmo_clear err,busy=%b want=00", {bus.err, bus.busy});
    end
`else
    repeat (300) begin
      @(negedge clk);
      if (bus.out_valid) ov++;
    end
    checks++;
    if ({bus.busy, bus.err} !== 2'b10 || ov != 0) begin
      errors++;
      $display("FAIL wait_forever busy,err=%b outs=%0d want 10/0", {bus.busy, bus.err}, ov);
    end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL wait_reset busy=%b want=0", bus.busy); end
`endif
    rdy_delay = 50;
  endtask

  initial begin
    bus.enable = 0;
    bus.adc_valid = 0;
    bus.adc_data = '0;
    bus.out_ready = 0;
    test_reset();
    test_enable();
    test_back_to_back();
    test_start_gap();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
